// File: rtl/f2_sweep_pkg.sv
// Shared types and sizes for the f2 exhaustive sweep controller.
package f2_sweep_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;
endpackage

// File: rtl/f2_settle_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module f2_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (en && cnt != '0)      cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/f2_sweep_ctrl.sv
// Walks f2 through all 16 input vectors, captures f into a truth table and scores it.
module f2_sweep_ctrl
  import f2_sweep_pkg::*;
#(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic                   pass
);
  // Timer counts SETTLE-1 down to 0, giving SETTLE cycles in the settle state.
  localparam logic [7:0] LOAD_VAL = 8'(SETTLE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             accept, last, tmr_load, tmr_en, tmr_expired;

  assign accept   = (state == S_IDLE) && start && !abort;
  assign last     = (idx == IDX_W'(NUM_VECTORS - 1));
  assign tmr_load = accept || ((state == S_SAMPLE) && !abort && !last);
  assign tmr_en   = (state == S_SETTLE);

  f2_settle_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (LOAD_VAL),
    .expired  (tmr_expired)
  );

  // idx is itself a flop, so the vector outputs are registered.
  assign {a, b, c, d} = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth_table  <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            idx          <= '0;
            truth_table  <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (tmr_expired) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            truth_table[idx] <= f;
            if (f != EXPECTED[idx]) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          pass  <= (mismatch_cnt == '0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_f2_sweep_ctrl.sv
// Bench for f2_sweep_ctrl: two instances (SETTLE=1/EXPECTED=6996, SETTLE=3/EXPECTED=6997).
module tb_f2_sweep_ctrl;
  localparam int          SET  [2] = '{1, 3};
  localparam logic [15:0] EXPV [2] = '{16'h6996, 16'h6997};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0, abort = '0;
  logic [1:0]  f, a, b, c, d, busy, done, pass;
  logic [15:0] tt [2];
  logic [4:0]  mc [2];
  logic [15:0] fn [2];
  int          edge_n = 0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // f2 stand-in: f is looked up from a bench-held truth function of {a,b,c,d}.
  assign f[0] = fn[0][{a[0], b[0], c[0], d[0]}];
  assign f[1] = fn[1][{a[1], b[1], c[1], d[1]}];

  f2_sweep_ctrl #(.SETTLE(1), .EXPECTED(16'h6996)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .f(f[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .busy(busy[0]), .done(done[0]),
    .truth_table(tt[0]), .mismatch_cnt(mc[0]), .pass(pass[0]));

  f2_sweep_ctrl #(.SETTLE(3), .EXPECTED(16'h6997)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .f(f[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .busy(busy[1]), .done(done[1]),
    .truth_table(tt[1]), .mismatch_cnt(mc[1]), .pass(pass[1]));

  typedef struct {
    logic [15:0] fv;
    logic [15:0] exp_tt;
    logic [4:0]  exp_mc;
    logic        exp_pass;
  } vec_t;

  function automatic logic [3:0] vec(input int u);
    return {a[u], b[u], c[u], d[u]};
  endfunction

  function automatic logic [27:0] outs(input int u);
    return {a[u], b[u], c[u], d[u], busy[u], done[u], pass[u], mc[u], tt[u]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // One full sweep; timing model: vector at offset t is t/(S+1), done at 16*(S+1).
  task automatic sweep(input int u, input logic [15:0] fv, input logic repulse,
                       input logic [15:0] exp_tt, input logic [4:0] exp_mc, input logic exp_pass);
    int k, t, bad, s;
    logic seen;
    s = SET[u];
    fn[u] = fv;
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    k = edge_n;
    check("accept_busy", 32'(busy[u]), 1);
    check("vec0", 32'(vec(u)), 0);
    bad = 0; seen = 1'b0; t = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      t = edge_n - k;
      if (repulse) start[u] = (t == 10);
      if (done[u]) seen = 1'b1;
      else if (vec(u) != 4'(t / (s + 1))) bad++;
    end
    start[u] = 1'b0;
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(t), 32'(16 * (s + 1)));
    check("busy_in_done", 32'(busy[u]), 0);
    check("vec_order", 32'(bad), 0);
    tick();
    check("done_width", 32'(done[u]), 0);
    check("truth_table", 32'(tt[u]), 32'(exp_tt));
    check("mismatch_cnt", 32'(mc[u]), 32'(exp_mc));
    check("pass", 32'(pass[u]), 32'(exp_pass));
    check("vec_hold_f", 32'(vec(u)), 32'hF);
  endtask

  // Reference model for random sweeps: capture equals f's function, score by popcount.
  task automatic sweep_model(input int u, input logic [15:0] fv);
    int m;
    m = $countones(fv ^ EXPV[u]);
    sweep(u, fv, 1'b0, fv, 5'(m), m == 0);
  endtask

  vec_t tbl [5];

  initial begin
    logic [15:0] fv;
    int d1, d2, cnt_done, cnt_busy;
    fn[0] = 16'h0; fn[1] = 16'h0;

    tbl[0] = '{16'h6996, 16'h6996, 5'd0,  1'b1};
    tbl[1] = '{16'h6997, 16'h6997, 5'd1,  1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 5'd8,  1'b0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 5'd8,  1'b0};
    tbl[4] = '{16'h9669, 16'h9669, 5'd16, 1'b0};

    // Reset and idle with no start.
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("reset_idle_u0", 32'(outs(0)), 0);
      check("reset_idle_u1", 32'(outs(1)), 0);
    end

    // Table-driven sweeps on the SETTLE=1 instance.
    for (int i = 0; i < 5; i++)
      sweep(0, tbl[i].fv, 1'b0, tbl[i].exp_tt, tbl[i].exp_mc, tbl[i].exp_pass);

    // XOR model against 6997 with SETTLE=3: one mismatch, 64-cycle sweep.
    sweep(1, 16'h6996, 1'b0, 16'h6996, 5'd1, 1'b0);

    // Abort during vector 5: partial capture of bits 0..4 only.
    fv = 16'($urandom);
    fn[0] = fv;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 100 && vec(0) != 4'd5; i++) tick();
    check("reach_vec5", 32'(vec(0)), 5);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_busy", 32'(busy[0]), 0);
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt_done += 32'(done[0]);
      cnt_busy += 32'(busy[0]);
    end
    check("abort_no_done", 32'(cnt_done), 0);
    check("abort_stays_idle", 32'(cnt_busy), 0);
    check("abort_tt", 32'(tt[0]), 32'(fv & 16'h001F));
    check("abort_mc", 32'(mc[0]), 32'($countones((fv ^ 16'h6996) & 16'h001F)));
    check("abort_pass", 32'(pass[0]), 0);

    // start with abort in IDLE is refused; partial results untouched.
    start[0] = 1'b1; abort[0] = 1'b1;
    cnt_busy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt_busy += 32'(busy[0]);
    end
    start[0] = 1'b0; abort[0] = 1'b0;
    tick();
    check("start_abort_busy", 32'(cnt_busy + 32'(busy[0])), 0);
    check("start_abort_tt", 32'(tt[0]), 32'(fv & 16'h001F));

    // start re-pulsed mid-sweep must not disturb timing.
    sweep(0, 16'h6996, 1'b1, 16'h6996, 5'd0, 1'b1);

    // Back-to-back: start held through DONE, one idle cycle between sweeps (gap 34).
    fn[0] = 16'h6996;
    start[0] = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 200 && d2 < 0; i++) begin
      tick();
      if (done[0]) begin
        if (d1 < 0) d1 = edge_n;
        else begin d2 = edge_n; start[0] = 1'b0; end
      end
    end
    start[0] = 1'b0;
    check("b2b_gap", 32'(d2 - d1), 34);
    repeat (3) tick();
    check("b2b_idle", 32'(busy[0]), 0);

    // Asynchronous reset mid-sweep, between edges.
    fn[0] = 16'h1234; fn[1] = 16'hBEEF;
    start = 2'b11;
    tick();
    start = 2'b00;
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_u0", 32'(outs(0)), 0);
    check("async_rst_u1", 32'(outs(1)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sweep_model(0, 16'($urandom));
    sweep_model(1, 16'($urandom));

    // Randomized sweeps against the popcount model.
    for (int i = 0; i < 8; i++) begin
      fv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) fv = EXPV[i % 2];
      sweep_model(i % 2, fv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
